// File: rtl/io_uart_tx.sv
// io_uart_tx: CPU port-mapped 8N1 serial transmitter with toggle handshake and byte FIFO.
`timescale 1ns/1ps
module io_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] io_out_data,
    input  logic [7:0] io_out_ctrl,
    output logic [7:0] io_in_status,
    output logic       txd
);
    localparam int AW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count, bitcnt;
    logic [1:0]    state;
    logic [15:0]   div;
    logic [7:0]    shift;
    logic          armed, req_q, ack, ovf, txd_q;
    logic          toggle, pop, push, div_end;
    logic          unused_ctrl;

    assign unused_ctrl = ^io_out_ctrl[7:2];
    assign toggle = armed && (io_out_ctrl[0] != req_q);
    assign pop = (state == IDLE) && (count != 3'd0);
    // a full FIFO still accepts when the head leaves on the same edge
    assign push = toggle && ((count < DEPTH) || pop);
    assign div_end = div == DIV_LAST;
    assign io_in_status = {count, ovf, ack, count == 3'd0, count == DEPTH, state != IDLE};
    assign txd = txd_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io_out_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
            bitcnt <= 3'd0;
            state  <= IDLE;
            div    <= 16'd0;
            shift  <= 8'd0;
            armed  <= 1'b0;
            req_q  <= 1'b0;
            ack    <= 1'b0;
            ovf    <= 1'b0;
            txd_q  <= 1'b1;
        end else begin
            // first edge after reset only samples the toggle level
            if (!armed) begin
                armed <= 1'b1;
                req_q <= io_out_ctrl[0];
            end else if (toggle) begin
                req_q <= io_out_ctrl[0];
                ack   <= ~ack;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {2'b0, push} - {2'b0, pop};
            if (toggle && !push) ovf <= 1'b1;
            else if (io_out_ctrl[1]) ovf <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    shift <= mem[rd_ptr];
                    div   <= 16'd0;
                    txd_q <= 1'b0;
                    state <= START;
                end
                START: if (div_end) begin
                    div    <= 16'd0;
                    bitcnt <= 3'd0;
                    txd_q  <= shift[0];
                    state  <= DATA;
                end else div <= div + 16'd1;
                DATA: if (div_end) begin
                    div    <= 16'd0;
                    shift  <= shift >> 1;
                    bitcnt <= bitcnt + 3'd1;
                    txd_q  <= (bitcnt == 3'd7) ? 1'b1 : shift[1];
                    state  <= (bitcnt == 3'd7) ? STOP : DATA;
                end else div <= div + 16'd1;
                default: if (div_end) begin
                    div   <= 16'd0;
                    state <= IDLE;
                end else div <= div + 16'd1;
            endcase
        end
    end
endmodule
